sample_timer: RTL and testbench
===============================

SAMPLE_TIMER -- requirements
Module: sample_timer

Interface
REQ-001 Parameter CNT_BITS, default 8, width of bit_period and of the internal period counter.
REQ-002 Parameter MAX_BITS, default 9, largest data_size accepted; IDX_BITS = $clog2(MAX_BITS+1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin a frame; sampled only in IDLE.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 bit_period  input  CNT_BITS  clocks per bit; latched at start acceptance.
REQ-008 data_size  input  4  strobes per frame; latched at start acceptance.
REQ-009 shift_strobe  output  1  one-clock pulse at each bit-centre sample point.
REQ-010 frame_done  output  1  one-clock pulse at frame end.
REQ-011 busy  output  1  high while a frame is in progress (states HALF, RUN, DONE).
REQ-012 bit_count  output  IDX_BITS  number of strobes issued in the current or most recent frame.

Function
REQ-013 States: IDLE, HALF, RUN and DONE; all outputs are registered.
REQ-014 IDLE: start=1 and abort=0 at edge E0 -> HALF; latch P=max(bit_period,2) and N=clamp(data_size,1,MAX_BITS); clear the period counter and bit_count.
REQ-015 Start is accepted in IDLE only; start in any other state is ignored, with no queueing.
REQ-016 HALF: the first shift_strobe is high during the (P + floor(P/2))-th cycle after E0; in that cycle bit_count becomes 1 and the state moves to RUN, or to DONE if N=1.
REQ-017 RUN: each subsequent shift_strobe follows the previous one by exactly P cycles; bit_count increments by 1 with each strobe.
REQ-018 The strobe that makes bit_count equal N moves the state to DONE on the next edge.
REQ-019 DONE: lasts exactly one cycle; frame_done=1, shift_strobe=0, busy=1; then IDLE.
REQ-020 frame_done is therefore high exactly one cycle after the last strobe.
REQ-021 In IDLE: busy=0, shift_strobe=0 and frame_done=0; bit_count holds its final value until the next accepted start.
REQ-022 The period counter is CNT_BITS+1 bits wide so the 1.5*P target never overflows; no wrap occurs for any bit_period value.
REQ-023 Changes to bit_period or data_size while busy have no effect on the current frame.
REQ-024 abort=1 in HALF, RUN or DONE -> IDLE on the next edge, with no shift_strobe or frame_done in that cycle; abort has priority over a coincident strobe or frame_done; bit_count holds.
REQ-025 abort=1 with start=1 in IDLE -> the start is not accepted.
REQ-026 A start asserted in the cycle the block returns to IDLE is accepted, so back-to-back frames are separated by one IDLE cycle.

Reset
REQ-027 n_rst=0 at a rising edge -> state IDLE, counters 0, shift_strobe=0, frame_done=0, busy=0, bit_count=0.
REQ-028 n_rst=0 takes priority over start and abort and aborts any frame in progress with no further pulses.
REQ-029 After n_rst returns to 1, the first start can be accepted on the next edge.

Verification
REQ-030 P=10, N=8, start pulse at E0 -> strobes in cycles 15,25,...,85; frame_done in cycle 86; busy high in cycles 1-86; bit_count=8.
REQ-031 bit_period=0 and bit_period=1, N=2 -> both behave as P=2: strobes in cycles 3 and 5, frame_done in cycle 6.
REQ-032 P=255, N=MAX_BITS=9 -> first strobe in cycle 382, spacing 255, no counter wrap; data_size=0 gives 1 strobe; data_size=15 gives 9 strobes.
REQ-033 abort coincident with the 4th strobe -> no strobe in that cycle, IDLE next cycle, bit_count=3, no frame_done.
REQ-034 bit_period changed from 10 to 4 mid-frame and start re-pulsed while busy -> timing unchanged and no second frame; a start in the first IDLE cycle after DONE is accepted.
REQ-035 n_rst=0 for one cycle mid-RUN -> all outputs 0 on the next cycle and no pulses until a new start.

Source files
------------

// File: rtl/sample_timer.sv
// Bit-centre sample timer.
// After an accepted start, the first sample strobe fires 1.5 bit periods in,
// and each later strobe follows one bit period after the one before it.
// A one-cycle frame_done pulse follows the last strobe. All outputs are
// registered. The FSM state is exported on o_state for observation.
//
// Handshake: i_start is a level request that is sampled only while idle.
// When i_start=1 and i_abort=0 at a rising edge in IDLE, the frame is accepted
// on that edge. Nothing is queued. i_abort cancels a frame in progress at the
// next edge.
module sample_timer #(
    parameter  int CNT_BITS = 8,
    parameter  int MAX_BITS = 9,
    localparam int IDX_BITS = $clog2(MAX_BITS + 1)
) (
    input  logic                i_clk,
    input  logic                i_n_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [CNT_BITS-1:0] i_bit_period,
    input  logic [3:0]          i_data_size,
    output logic                o_shift_strobe,
    output logic                o_frame_done,
    output logic                o_busy,
    output logic [IDX_BITS-1:0] o_bit_count,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_period;      // latched bit period, never below 2
    logic [IDX_BITS-1:0] r_num;         // latched strobes per frame, 1..MAX_BITS
    logic [CNT_BITS:0]   r_cnt;         // one extra bit so 1.5*P always fits
    logic [IDX_BITS-1:0] r_bit_count;
    logic                r_shift_strobe;
    logic                r_frame_done;
    logic                r_busy;

    logic [CNT_BITS-1:0] w_period_in;
    logic [IDX_BITS-1:0] w_num_in;
    logic [CNT_BITS:0]   w_period_ext;
    logic [CNT_BITS:0]   w_half_target;
    logic [CNT_BITS:0]   w_run_target;
    logic                w_half_hit;
    logic                w_run_hit;
    logic                w_last_done;
    logic [IDX_BITS-1:0] w_bit_count_inc;

    // Clamp the frame parameters presented at start, and derive the counter
    // targets from the latched period.
    always_comb begin
        w_period_in = i_bit_period;
        if (i_bit_period < CNT_BITS'(2)) begin
            w_period_in = CNT_BITS'(2);
        end

        w_num_in = IDX_BITS'(i_data_size);
        if (i_data_size == 4'd0) begin
            w_num_in = IDX_BITS'(1);
        end else if (int'(i_data_size) > MAX_BITS) begin
            w_num_in = IDX_BITS'(MAX_BITS);
        end

        // The counter reads 0 in the first cycle of a phase. The half-phase
        // fires when it reads T-2, so the strobe lands in cycle T = P + P/2.
        // The run phase fires when it reads P-1, giving an exact P spacing.
        w_period_ext    = {1'b0, r_period};
        w_half_target   = w_period_ext + (w_period_ext >> 1) - (CNT_BITS + 1)'(2);
        w_run_target    = w_period_ext - (CNT_BITS + 1)'(1);
        w_half_hit      = (r_cnt == w_half_target);
        w_run_hit       = (r_cnt == w_run_target);
        w_last_done     = (r_bit_count == r_num);
        w_bit_count_inc = r_bit_count + IDX_BITS'(1);
    end

    // Frame FSM, period counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_state        <= S_IDLE;
            r_period       <= '0;
            r_num          <= '0;
            r_cnt          <= '0;
            r_bit_count    <= '0;
            r_shift_strobe <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_shift_strobe <= 1'b0;
            r_frame_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state     <= S_HALF;
                        r_period    <= w_period_in;
                        r_num       <= w_num_in;
                        r_cnt       <= '0;
                        r_bit_count <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_HALF: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_half_hit) begin
                        r_state        <= S_RUN;
                        r_shift_strobe <= 1'b1;
                        r_bit_count    <= w_bit_count_inc;
                        r_cnt          <= '0;
                    end else begin
                        r_cnt <= r_cnt + (CNT_BITS + 1)'(1);
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_last_done) begin
                        // The last strobe was issued in this cycle.
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else if (w_run_hit) begin
                        r_shift_strobe <= 1'b1;
                        r_bit_count    <= w_bit_count_inc;
                        r_cnt          <= '0;
                    end else begin
                        r_cnt <= r_cnt + (CNT_BITS + 1)'(1);
                    end
                end
                S_DONE: begin
                    // Abort here leads to the same result: back to idle.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_shift_strobe = r_shift_strobe;
    assign o_frame_done   = r_frame_done;
    assign o_busy         = r_busy;
    assign o_bit_count    = r_bit_count;
    assign o_state        = r_state;

endmodule

// File: tb/tb_sample_timer.sv
// Bench for sample_timer. A timeline model predicts every output in every
// cycle from the frame start edge, the clamped P and N, and the abort and
// reset events. Directed frames pin the model to hand-computed cycle numbers.
module tb_sample_timer;

  localparam int CNT_BITS = 8;
  localparam int MAX_BITS = 9;
  localparam int IDX_BITS = $clog2(MAX_BITS + 1);

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CNT_BITS-1:0] bit_period = '0;
  logic [3:0] data_size = '0;
  logic o_shift_strobe;
  logic o_frame_done;
  logic o_busy;
  logic [IDX_BITS-1:0] o_bit_count;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  sample_timer #(.CNT_BITS(CNT_BITS), .MAX_BITS(MAX_BITS)) dut (
    .i_clk(clk),
    .i_n_rst(n_rst),
    .i_start(start),
    .i_abort(abort),
    .i_bit_period(bit_period),
    .i_data_size(data_size),
    .o_shift_strobe(o_shift_strobe),
    .o_frame_done(o_frame_done),
    .o_busy(o_busy),
    .o_bit_count(o_bit_count),
    .o_state(o_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // Timeline model. Edge e is followed by cycle e. In a frame accepted at
  // edge m_e0, spec cycle k is the cycle after edge m_e0 + k - 1.
  int edge_cnt = 0;
  bit m_valid = 1'b0;
  bit m_act = 1'b0;
  int m_e0 = 0;
  int m_p = 2;
  int m_n = 1;
  int m_held = 0;

  // Observed frame statistics, cleared at each accepted start.
  int st_cnt = 0;
  int st_first = -1;
  int st_last = -1;
  int st_fd = -1;
  int st_busy = 0;

  function automatic int m_t();
    return m_p + m_p / 2;
  endfunction

  function automatic int m_end();
    return m_t() + (m_n - 1) * m_p + 1;
  endfunction

  function automatic int m_k(input int c);
    return c - m_e0 + 1;
  endfunction

  function automatic bit m_busy(input int c);
    int k;
    k = m_k(c);
    return m_act && k >= 1 && k <= m_end();
  endfunction

  function automatic bit m_strobe(input int c);
    int k;
    k = m_k(c);
    if (!m_act || k < m_t()) return 1'b0;
    return ((k - m_t()) % m_p == 0) && ((k - m_t()) / m_p < m_n);
  endfunction

  function automatic bit m_fd(input int c);
    return m_act && m_k(c) == m_end();
  endfunction

  function automatic int m_bc(input int c);
    int k;
    int v;
    if (!m_act) return m_held;
    k = m_k(c);
    if (k < m_t()) return 0;
    v = (k - m_t()) / m_p + 1;
    return (v > m_n) ? m_n : v;
  endfunction

  // Model update on each rising edge, using the inputs the DUT sees.
  always @(posedge clk) begin
    edge_cnt++;
    if (!n_rst) begin
      m_act = 1'b0;
      m_held = 0;
      m_valid = 1'b1;
    end else if (m_busy(edge_cnt - 1)) begin
      if (abort) begin
        m_held = m_bc(edge_cnt - 1);
        m_act = 1'b0;
      end
    end else begin
      if (m_act) begin
        m_held = m_n;
        m_act = 1'b0;
      end
      if (start && !abort) begin
        m_act = 1'b1;
        m_e0 = edge_cnt;
        m_p = (int'(bit_period) < 2) ? 2 : int'(bit_period);
        m_n = (data_size == 4'd0) ? 1 : ((int'(data_size) > MAX_BITS) ? MAX_BITS : int'(data_size));
        st_cnt = 0;
        st_first = -1;
        st_last = -1;
        st_fd = -1;
        st_busy = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("shift_strobe", int'(o_shift_strobe), int'(m_strobe(edge_cnt)));
      check("frame_done", int'(o_frame_done), int'(m_fd(edge_cnt)));
      check("busy", int'(o_busy), int'(m_busy(edge_cnt)));
      check("bit_count", int'(o_bit_count), m_bc(edge_cnt));
      if (o_shift_strobe) begin
        st_cnt++;
        if (st_first < 0) st_first = m_k(edge_cnt);
        st_last = m_k(edge_cnt);
      end
      if (o_frame_done) st_fd = m_k(edge_cnt);
      if (o_busy) st_busy++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input int bp, input int ds);
    bit_period = CNT_BITS'(bp);
    data_size = 4'(ds);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int guard;
    guard = 0;
    while (m_k(edge_cnt) < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("wait_k_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int guard;
    guard = 0;
    while (o_busy && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= budget) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    n_rst = 1'b0;
    tick(3);
    n_rst = 1'b1;
    check("reset_busy", int'(o_busy), 0);
    check("reset_bit_count", int'(o_bit_count), 0);
    tick(2);

    // P=10, N=8
    start_frame(10, 8);
    wait_idle(200);
    check("p10_first", st_first, 15);
    check("p10_last", st_last, 85);
    check("p10_count", st_cnt, 8);
    check("p10_done", st_fd, 86);
    check("p10_busy_len", st_busy, 86);
    check("p10_bc", int'(o_bit_count), 8);
    tick(2);

    // bit_period 0 and 1 both act as P=2
    for (int bp = 0; bp < 2; bp++) begin
      start_frame(bp, 2);
      wait_idle(100);
      check("p2_first", st_first, 3);
      check("p2_last", st_last, 5);
      check("p2_count", st_cnt, 2);
      check("p2_done", st_fd, 6);
      tick(1);
    end

    // P=255, data_size=15 clamps to 9 strobes
    start_frame(255, 15);
    wait_idle(3000);
    check("p255_first", st_first, 382);
    check("p255_last", st_last, 2422);
    check("p255_count", st_cnt, 9);
    check("p255_done", st_fd, 2423);
    tick(1);
    // data_size=0 gives one strobe
    start_frame(255, 0);
    wait_idle(1000);
    check("ds0_count", st_cnt, 1);
    check("ds0_done", st_fd, 383);
    check("ds0_bc", int'(o_bit_count), 1);
    tick(2);

    // abort coincident with the 4th strobe
    start_frame(10, 8);
    wait_k(44);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_strobe", int'(o_shift_strobe), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_bc", int'(o_bit_count), 3);
    tick(20);
    check("abort_count", st_cnt, 3);
    check("abort_no_done", st_fd, -1);

    // parameter change and start re-pulse while busy
    start_frame(10, 3);
    wait_k(20);
    bit_period = 8'd4;
    data_size = 4'd9;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(200);
    check("busy_first", st_first, 15);
    check("busy_last", st_last, 35);
    check("busy_count", st_cnt, 3);
    check("busy_done", st_fd, 36);
    // start in the first idle cycle after DONE is accepted
    start_frame(4, 1);
    check("b2b_busy", int'(o_busy), 1);
    wait_idle(100);
    check("b2b_first", st_first, 6);
    check("b2b_done", st_fd, 7);
    tick(2);

    // reset pulse mid-run
    start_frame(10, 8);
    wait_k(30);
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    check("rst_strobe", int'(o_shift_strobe), 0);
    check("rst_done", int'(o_frame_done), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_bc", int'(o_bit_count), 0);
    tick(60);
    check("rst_no_pulses", st_cnt, 2);
    check("rst_no_done", st_fd, -1);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      bit_period = CNT_BITS'($urandom_range(0, 40));
      data_size = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 150) == 0);
      n_rst = !($urandom_range(0, 1500) == 0);
      @(negedge clk);
    end
    n_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
